// File: rtl/life_engine.sv
// life_engine: Game-of-Life generation engine for an X-by-Y board.
// A start pulse in IDLE scans every cell once (one cell per clock) into a
// shadow register, then commits the shadow as the new generation.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, wrap                run one generation; wrap=1 selects a toroidal board
//   edit_toggle, edit_x/y      invert one cell while idle
//   rd_y, row                  registered readout of committed row rd_y
//   busy, done                 scan/commit in progress, one-cycle completion pulse
//   gen_cnt, extinct, still    generation count and status of the last commit
//
// state  | meaning
// IDLE   | waiting; accepts edits and start
// SCAN   | computing next state of cell (sx,sy) into shadow
// COMMIT | shadow becomes the board, status updated
module life_engine #(
  parameter int X = 8,
  parameter int Y = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter int GEN_W = 16,
  parameter logic [8:0] BIRTH_MASK = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
  parameter logic [X*Y-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             wrap,
  input  logic             edit_toggle,
  input  logic [LOG2X-1:0] edit_x,
  input  logic [LOG2Y-1:0] edit_y,
  input  logic [LOG2Y-1:0] rd_y,
  output logic [X-1:0]     row,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_cnt,
  output logic             extinct,
  output logic             still
);

  localparam int N = X * Y;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state, state_next;

  logic [N-1:0]     board;
  logic [N-1:0]     shadow;
  logic [LOG2X-1:0] sx;
  logic [LOG2Y-1:0] sy;
  logic             wrap_q;
  logic             scan_last;
  logic             edit_ok;
  logic [3:0]       nbr;
  logic             cell_next;
  logic [IW-1:0]    cur_idx;
  logic [IW-1:0]    edit_idx;
  logic [X-1:0]     row_next;
  int               xi;
  int               yi;

  assign scan_last = (int'(sx) == X - 1) && (int'(sy) == Y - 1);
  assign edit_ok   = edit_toggle && (int'(edit_x) < X) && (int'(edit_y) < Y);
  assign edit_idx  = IW'(int'(edit_y) * X + int'(edit_x));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE:    if (start && !edit_toggle) state_next = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (scan_last) state_next = COMMIT;
      end
      COMMIT: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Neighbour count of the cell under the scan index, always taken from the
  // committed board so every cell sees the same generation.
  always_comb begin
    nbr = '0;
    xi  = 0;
    yi  = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xi = int'(sx) + dx;
        yi = int'(sy) + dy;
        if (wrap_q) begin
          if (xi < 0)       xi = X - 1;
          else if (xi >= X) xi = 0;
          if (yi < 0)       yi = Y - 1;
          else if (yi >= Y) yi = 0;
        end
        if (!(dx == 0 && dy == 0) && xi >= 0 && xi < X && yi >= 0 && yi < Y)
          nbr = nbr + 4'(board[IW'(yi * X + xi)]);
      end
    end
    cur_idx   = IW'(int'(sy) * X + int'(sx));
    cell_next = board[cur_idx] ? SURVIVE_MASK[nbr] : BIRTH_MASK[nbr];
  end

  always_comb begin
    row_next = '0;
    if (int'(rd_y) < Y) begin
      for (int x = 0; x < X; x++)
        row_next[x] = board[IW'(int'(rd_y) * X + x)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      board   <= INIT;
      sx      <= '0;
      sy      <= '0;
      wrap_q  <= 1'b0;
      row     <= '0;
      done    <= 1'b0;
      gen_cnt <= '0;
      extinct <= 1'b0;
      still   <= 1'b0;
    end else begin
      done <= 1'b0;
      row  <= row_next;
      case (state)
        IDLE: begin
          // An edit takes priority over a start in the same cycle.
          if (edit_toggle) begin
            if (edit_ok) board[edit_idx] <= ~board[edit_idx];
          end else if (start) begin
            wrap_q <= wrap;
            sx     <= '0;
            sy     <= '0;
          end
        end
        SCAN: begin
          shadow[cur_idx] <= cell_next;
          if (int'(sx) == X - 1) begin
            sx <= '0;
            sy <= scan_last ? '0 : sy + LOG2Y'(1);
          end else begin
            sx <= sx + LOG2X'(1);
          end
        end
        COMMIT: begin
          board   <= shadow;
          gen_cnt <= gen_cnt + GEN_W'(1);
          extinct <= (shadow == '0);
          still   <= (shadow == board);
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_engine.sv
module tb_life_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, wrap = 1'b0, edit_toggle = 1'b0;
  logic [2:0] edit_x = '0, edit_y = '0, rd_y = '0;
  logic [7:0] row;
  logic       busy, done, extinct, still;
  logic [15:0] gen_cnt;

  logic       b_start = 1'b0, b_wrap = 1'b0, b_edit_toggle = 1'b0;
  logic [3:0] b_edit_x = '0;
  logic [1:0] b_edit_y = '0, b_rd_y = '0;
  logic [9:0] b_row;
  logic       b_busy, b_done, b_extinct, b_still;
  logic [1:0] b_gen_cnt;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;
  logic [63:0] mb;
  int          mgen;
  logic        mext, mstill;

  always #5 clk = ~clk;

  life_engine dut (
    .clk(clk), .reset(reset), .start(start), .wrap(wrap),
    .edit_toggle(edit_toggle), .edit_x(edit_x), .edit_y(edit_y), .rd_y(rd_y),
    .row(row), .busy(busy), .done(done), .gen_cnt(gen_cnt),
    .extinct(extinct), .still(still)
  );

  life_engine #(.X(10), .Y(3), .LOG2X(4), .LOG2Y(2), .GEN_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .wrap(b_wrap),
    .edit_toggle(b_edit_toggle), .edit_x(b_edit_x), .edit_y(b_edit_y), .rd_y(b_rd_y),
    .row(b_row), .busy(b_busy), .done(b_done), .gen_cnt(b_gen_cnt),
    .extinct(b_extinct), .still(b_still)
  );

  // Reference generation step, B3/S23, board bit index y*8+x.
  function automatic logic [63:0] life_step(input logic [63:0] b, input logic w);
    logic [63:0] nb;
    int n, xx, yy;
    logic alive;
    nb = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            xx = x + dx;
            yy = y + dy;
            if (w) begin
              xx = (xx + 8) % 8;
              yy = (yy + 8) % 8;
            end
            if (!(dx == 0 && dy == 0) && xx >= 0 && xx < 8 && yy >= 0 && yy < 8)
              n += int'(b[6'(yy * 8 + xx)]);
          end
        end
        alive = b[6'(y * 8 + x)];
        nb[6'(y * 8 + x)] = alive ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return nb;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mb = '0;
    mgen = 0;
    mext = 1'b0;
    mstill = 1'b0;
  endtask

  task automatic toggle(input int x, input int y);
    edit_x = 3'(x);
    edit_y = 3'(y);
    edit_toggle = 1'b1;
    tick();
    edit_toggle = 1'b0;
    mb[6'(y * 8 + x)] = ~mb[6'(y * 8 + x)];
  endtask

  task automatic load(input logic [63:0] target);
    for (int i = 0; i < 64; i++)
      if (mb[i] !== target[i]) toggle(i % 8, i / 8);
  endtask

  task automatic check_rows(input string tag, input logic [63:0] exp);
    for (int y = 0; y < 8; y++) begin
      rd_y = 3'(y);
      tick();
      chk(tag, 32'(row), 32'(exp[y * 8 +: 8]));
    end
  endtask

  task automatic run_gen(input logic w, input bit mid_edit, input bit rows);
    int lat, bcnt;
    logic [63:0] nb;
    start = 1'b1;
    wrap = w;
    tick();
    start = 1'b0;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 300) begin
      if (mid_edit && lat == 10) begin
        edit_toggle = 1'b1;
        edit_x = 3'd2;
        edit_y = 3'd2;
        start = 1'b1;
      end
      tick();
      lat++;
      edit_toggle = 1'b0;
      start = 1'b0;
      if (busy) bcnt++;
    end
    chk("done_latency", 32'(lat), 32'd65);
    chk("busy_cycles", 32'(bcnt), 32'd65);
    if (done) done_pulses++;
    nb = life_step(mb, w);
    mstill = (nb == mb);
    mext = (nb == '0);
    mb = nb;
    mgen++;
    chk("gen_cnt", 32'(gen_cnt), 32'(16'(mgen)));
    chk("extinct", 32'(extinct), 32'(mext));
    chk("still", 32'(still), 32'(mstill));
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    if (rows) check_rows("board_row", mb);
  endtask

  initial begin
    logic [63:0] blk, glider, rnd, expb;
    int lat, d0;

    tick();
    reset = 1'b0;
    mb = '0; mgen = 0; mext = 1'b0; mstill = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_gen", 32'(gen_cnt), 32'd0);
    chk("rst_extinct", 32'(extinct), 32'd0);
    chk("rst_still", 32'(still), 32'd0);
    chk("rst_row", 32'(row), 32'd0);

    // Blinker, dead edges
    toggle(3, 4); toggle(4, 4); toggle(5, 4);
    run_gen(1'b0, 0, 1);
    for (int y = 0; y < 8; y++) begin
      rd_y = 3'(y);
      tick();
      chk("blinker_row", 32'(row), (y >= 3 && y <= 5) ? 32'h10 : 32'h0);
    end

    // Edge blinker, toroidal then dead edges
    do_reset();
    toggle(7, 3); toggle(0, 3); toggle(1, 3);
    run_gen(1'b1, 0, 1);
    for (int y = 2; y <= 4; y++) begin
      rd_y = 3'(y);
      tick();
      chk("edge_wrap_row", 32'(row), 32'h01);
    end
    do_reset();
    toggle(7, 3); toggle(0, 3); toggle(1, 3);
    run_gen(1'b0, 0, 1);
    chk("edge_dead_extinct", 32'(extinct), 32'd1);

    // Block is a still life
    do_reset();
    blk = '0;
    blk[2*8+2] = 1'b1; blk[2*8+3] = 1'b1; blk[3*8+2] = 1'b1; blk[3*8+3] = 1'b1;
    load(blk);
    run_gen(1'b0, 0, 0);
    chk("block_still1", 32'(still), 32'd1);
    run_gen(1'b0, 0, 1);
    chk("block_still2", 32'(still), 32'd1);
    chk("block_gen", 32'(gen_cnt), 32'd2);
    check_rows("block_rows", blk);

    // Glider returns home after 32 generations on a toroidal 8x8
    do_reset();
    glider = '0;
    glider[0*8+1] = 1'b1; glider[1*8+2] = 1'b1;
    glider[2*8+0] = 1'b1; glider[2*8+1] = 1'b1; glider[2*8+2] = 1'b1;
    load(glider);
    d0 = done_pulses;
    for (int g = 0; g < 32; g++) run_gen(1'b1, 0, 0);
    chk("glider_gen", 32'(gen_cnt), 32'd32);
    chk("glider_dones", 32'(done_pulses - d0), 32'd32);
    check_rows("glider_home", glider);

    // Edit and start while busy are ignored
    rnd = {$urandom, $urandom};
    load(rnd);
    run_gen(1'b1, 1, 1);

    // Start together with an edit in IDLE: edit wins, no scan
    start = 1'b1; edit_toggle = 1'b1; edit_x = 3'd0; edit_y = 3'd0;
    tick();
    start = 1'b0; edit_toggle = 1'b0;
    mb[0] = ~mb[0];
    chk("start_edit_busy", 32'(busy), 32'd0);
    tick();
    chk("start_edit_busy2", 32'(busy), 32'd0);
    check_rows("start_edit_row", mb);

    // Reset in the middle of a scan
    start = 1'b1; wrap = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mb = '0; mgen = 0; mext = 1'b0; mstill = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_gen", 32'(gen_cnt), 32'd0);
    chk("midrst_still", 32'(still), 32'd0);
    expb = '0;
    check_rows("midrst_init", expb);
    rnd = {$urandom, $urandom} & {$urandom, $urandom};
    load(rnd);
    run_gen(1'b0, 0, 1);

    // Random boards and edge modes against the reference model
    for (int r = 0; r < 6; r++) begin
      rnd = {$urandom, $urandom};
      if (r % 2 == 1) rnd = rnd & {$urandom, $urandom};
      load(rnd);
      for (int g = 0; g < 3; g++) run_gen(1'($urandom_range(0, 1)), 0, (g == 2));
    end

    // 10x3 instance: edit range, out-of-range readout, gen_cnt wrap
    do_reset();
    b_edit_x = 4'd9; b_edit_y = 2'd1; b_edit_toggle = 1'b1;
    tick();
    b_edit_toggle = 1'b0;
    b_rd_y = 2'd1;
    tick();
    chk("b_edit_x9", 32'(b_row), 32'h200);
    b_edit_x = 4'd10; b_edit_toggle = 1'b1;
    tick();
    b_edit_toggle = 1'b0;
    tick();
    chk("b_edit_x10", 32'(b_row), 32'h200);
    b_rd_y = 2'd3;
    tick();
    chk("b_rd_oob", 32'(b_row), 32'h0);
    for (int g = 0; g < 4; g++) begin
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      lat = 0;
      while (!b_done && lat < 100) begin
        tick();
        lat++;
      end
      chk("b_latency", 32'(lat), 32'd31);
      chk("b_gen_wrap", 32'(b_gen_cnt), 32'((g + 1) % 4));
      chk("b_extinct", 32'(b_extinct), 32'd1);
      chk("b_still", 32'(b_still), (g == 0) ? 32'd0 : 32'd1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/life_engine.md
Name: life_engine

Overview:
- Parametrised Game-of-Life generation engine for an X-by-Y board held in an internal board register.
- On a start pulse it scans every cell once, one cell per clock, into a shadow register, then commits the shadow register as the new generation.
- Adds what the fixed 8x8 datapath lacks: parametrised birth/survive rules, selectable toroidal or dead-edge boundary, single-cell edit, registered row readout, generation counter, and extinct/still status.
- Sits between the key/cursor front end and the display row driver.

Parameters:
- X, 8, board width in cells (>=3)
- Y, 8, board height in cells (>=3)
- LOG2X, 3, width of x indices, ceil(log2 X)
- LOG2Y, 3, width of y indices, ceil(log2 Y)
- GEN_W, 16, generation counter width
- BIRTH_MASK, 9'b000001000, bit n set: a dead cell with n live neighbours is born (default B3)
- SURVIVE_MASK, 9'b000001100, bit n set: a live cell with n live neighbours survives (default S23)
- INIT, {X*Y{1'b0}}, board contents after reset; cell (x,y) is bit y*X+x

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request one generation; sampled only in IDLE
- wrap  in  1  1 = toroidal board, 0 = outside cells dead; sampled with start
- edit_toggle  in  1  invert cell (edit_x, edit_y); sampled only in IDLE
- edit_x  in  LOG2X  edit column
- edit_y  in  LOG2Y  edit row
- rd_y  in  LOG2Y  row select for readout
- row  out  X  registered row rd_y of committed board; bit x = cell (x, rd_y)
- busy  out  1  high in SCAN and COMMIT
- done  out  1  one-cycle pulse, first cycle the new board is visible
- gen_cnt  out  GEN_W  committed generations, wraps modulo 2^GEN_W
- extinct  out  1  last committed board is all zero
- still  out  1  last committed board equals the board before it

Behaviour:
- Reset (any state, including mid-scan):
  - board=INIT; shadow register contents don't-care; state=IDLE.
  - busy=0, done=0, gen_cnt=0, extinct=0, still=0, row=0.
  - The wrap latch and the scan index clear to 0.
- States:
  - IDLE: start=1 and edit_toggle=0 -> SCAN. The wrap value is latched, scan index cnt=0, busy=1 from the next cycle.
  - SCAN: each cycle computes the next state of cell cnt from the committed board and stores it in shadow[cnt]; cnt++. When cnt=X*Y-1 -> COMMIT. SCAN lasts exactly X*Y cycles.
  - COMMIT: at the cycle's end, board<=shadow and gen_cnt<=gen_cnt+1. extinct<=(shadow==0), still<=(shadow==board), done<=1, busy<=0; -> IDLE.
  - Result: done is high exactly X*Y+1 cycles after the start-sampling edge.
- Next-state rule:
  - n = count of the 8 neighbours, 4-bit.
  - next = cell ? SURVIVE_MASK[n] : BIRTH_MASK[n].
- Neighbour coordinates:
  - wrap=1: x±1 mod X, y±1 mod Y.
  - wrap=0: coordinates outside 0..X-1 / 0..Y-1 read 0.
- The board is never modified during SCAN. All cells see generation g.
- Edit:
  - In IDLE, edit_toggle=1 with edit_x<X and edit_y<Y inverts that cell at the edge.
  - Out-of-range coordinates: no change.
  - Edit in the same cycle as start: the edit is applied and start is ignored.
  - edit_toggle and start while busy are ignored; there is no queueing.
  - Edits do not change gen_cnt, extinct or still.
- Readout:
  - row <= board row rd_y every cycle, 1-cycle latency; rd_y>=Y gives 0.
  - row shows the committed board only. A readout of the board just committed is valid from the cycle after done.
- done is high only in the single cycle after COMMIT.
- extinct and still hold their values until the next COMMIT.
- gen_cnt at 2^GEN_W-1 wraps to 0 on the next commit.

Test Plan:
- Blinker, wrap=0: 8x8, toggle (3,4),(4,4),(5,4), start.
  - busy=1 for 65 cycles; done 65 cycles after the start edge.
  - rd_y=3,4,5 give 8'h10 each; all other rows 0; gen_cnt=1, extinct=0, still=0.
- Edge blinker: cells (7,3),(0,3),(1,3).
  - wrap=1 -> rows 2,3,4 = 8'h01.
  - From the same initial board with wrap=0 -> all rows 0, extinct=1.
- Block: cells (2,2),(3,2),(2,3),(3,3), start twice.
  - Board unchanged; still=1 after each done; gen_cnt=2.
- Glider, wrap=1: cells (1,0),(2,1),(0,2),(1,2),(2,2); 32 back-to-back generations.
  - Board equals the initial board; gen_cnt=32; done pulses exactly 32 times.
- Protocol:
  - edit_toggle pulsed mid-SCAN -> board after done matches the unedited expectation.
  - start and edit in the same IDLE cycle -> cell inverted, busy stays 0.
  - edit_x=9 with X=10 is in range; edit_x=10 -> no change.
- Reset mid-scan:
  - Assert reset at cnt=20 -> next cycle busy=0, gen_cnt=0, board=INIT.
  - A new start then completes normally.
